uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

UART transmit controller and serializer. Accepts a parallel word, pulses the TX parity calculator to capture its parity, then drives the serial line with start, data (LSB first), optional parity and stop bits. It sits upstream of and alongside the TX parity calculator: it produces that block's enable and consumes its registered `par_bit`. One bit is transmitted per `CLK` cycle, so `CLK` is the baud-rate clock.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; must be ≥ 2.

- `CLK` in 1: baud-rate clock; all state changes on its rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `P_DATA` in DATA_WIDTH: parallel word; sampled only on the accept edge.
- `DATA_VALID` in 1: request to send `P_DATA`.
- `PAR_EN` in 1: parity-bit enable; sampled only on the accept edge.
- `par_bit` in 1: parity bit from the parity calculator; registered by that block on the accept edge.
- `par_calc_en` out 1: capture strobe to the parity calculator; equals the accept condition.
- `TX_OUT` out 1: serial line; idles high.
- `busy` out 1: high while a frame is in progress.

## Operation
- State machine states:
  - IDLE
  - START
  - DATA
  - PARITY
  - STOP
- Reset, asynchronous on `RST` low, including mid-frame:
  - state goes to IDLE.
  - `TX_OUT` goes to 1.
  - `busy` goes to 0.
  - Bit counter, data shift register and latched parity enable all clear to 0.
  - No partial frame resumes after reset is released.
- Accept condition is `DATA_VALID` high while state is IDLE or STOP. It is combinational.
  - `par_calc_en` equals the accept condition, so the parity calculator sees the same `P_DATA` on the same edge.
- On the accept edge:
  - `P_DATA` loads into the shift register.
  - `PAR_EN` is latched.
  - The bit counter clears.
  - State goes to START.
- `DATA_VALID` in START, DATA or PARITY is ignored. It does not queue and does not pulse `par_calc_en`.
- Transitions:
  - IDLE → START on accept.
  - START → DATA unconditionally.
  - DATA → DATA while counter < DATA_WIDTH−1. Each edge shifts right by one and increments the counter.
  - DATA → PARITY when counter = DATA_WIDTH−1 and latched PAR_EN = 1.
  - DATA → STOP when counter = DATA_WIDTH−1 and latched PAR_EN = 0.
  - PARITY → STOP unconditionally.
  - STOP → START on accept (back-to-back frame).
  - STOP → IDLE otherwise.
- `TX_OUT` is driven from registered state only, with no combinational path from any input:
  - IDLE: 1.
  - START: 0.
  - DATA: shift register bit 0.
  - PARITY: `par_bit`.
  - STOP: 1.
- `busy` = state ≠ IDLE.
- Counter width is $clog2(DATA_WIDTH); it never wraps inside a frame.

## Timing
- Accept at edge 0. Start bit appears in cycle 1; data bit i appears in cycle 2+i.
- With parity, the parity bit appears in cycle DATA_WIDTH+2 and the stop bit in cycle DATA_WIDTH+3.
- Without parity, the stop bit appears in cycle DATA_WIDTH+2.
- Frame length is DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity.
- `par_bit` is valid from cycle 1 onward, long before the PARITY slot. It is not re-sampled by this block; the calculator holds it until the next `par_calc_en`.
- Back-to-back: `DATA_VALID` high in the STOP cycle puts the next start bit in the very next cycle, with zero idle gap.
- `busy` rises in cycle 1 (the START cycle).
  - If nothing is accepted in STOP, `busy` falls in the cycle after the STOP cycle.
  - Under continuous back-to-back traffic, `busy` stays high.
- `par_calc_en` is high for exactly one cycle per accepted frame and never while the state is START, DATA or PARITY.

## Test plan
- DATA_WIDTH=8, `P_DATA`=0xA5, `PAR_EN`=0, single `DATA_VALID` pulse in IDLE → `TX_OUT` over cycles 1..10 = 0,1,0,1,0,0,1,0,1,1. `busy` high in cycles 1..10, then low. `par_calc_en` is one pulse at accept.
- `P_DATA`=0xA5 with `PAR_EN`=1, parity calculator in even mode (`par_bit`=0) → cycle 10 = 0, cycle 11 = 1 (stop), 11-cycle frame. Repeat in odd mode (`par_bit`=1) → cycle 10 = 1.
- Back-to-back: 0x0F then 0xF0, `PAR_EN`=0, second `DATA_VALID` asserted in the STOP cycle → second start bit in cycle 11, `busy` never drops, two `par_calc_en` pulses exactly 10 cycles apart.
- `DATA_VALID` held high with 0x33 while sending 0x55 (state in DATA) → 0x33 is not transmitted or captured mid-frame. With `DATA_VALID` still high in STOP, 0x33 is accepted there and starts immediately.
- `RST` pulled low in the 4th data bit of 0xFF → `TX_OUT`=1 and `busy`=0 immediately (asynchronously). After release with `DATA_VALID` low, the line stays high with no residual bits.
- `PAR_EN` toggled mid-frame → frame length follows the value latched at accept (10 or 11 cycles).

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit controller and serializer. A parallel word is accepted when
// DATA_VALID is high while the line is idle or sending its stop bit. The same
// edge strobes the external parity calculator. The frame is then sent one bit
// per CLK cycle: start (0), data LSB first, optional parity, stop (1).
//
// Ports
//   CLK         in  1           baud-rate clock, rising edge
//   RST         in  1           asynchronous active-low reset
//   P_DATA      in  DATA_WIDTH  parallel word, sampled on the accept edge
//   DATA_VALID  in  1           request to send P_DATA
//   PAR_EN      in  1           parity enable, sampled on the accept edge
//   par_bit     in  1           registered parity from the parity calculator
//   par_calc_en out 1           capture strobe to the parity calculator
//   TX_OUT      out 1           serial line, idles high
//   busy        out 1           high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  par_bit,
   output logic                  par_calc_en,
   output logic                  TX_OUT,
   output logic                  busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   state_t                  state_r;
   logic [CNT_W-1:0]        cnt_r;
   logic [DATA_WIDTH-1:0]   shift_r;
   logic                    par_en_r;
   logic                    tx_out_r;
   logic                    busy_r;
   logic                    accept_s;

   // A new word is taken only when the line is free or in its last (stop) bit;
   // this lets back-to-back frames run with no idle gap.
   assign accept_s = DATA_VALID && ((state_r == ST_IDLE) || (state_r == ST_STOP));

   // The calculator must capture the very same P_DATA on the accept edge.
   assign par_calc_en = accept_s;
   assign TX_OUT      = tx_out_r;
   assign busy        = busy_r;

   // Frame sequencer. TX_OUT and busy are loaded with the value belonging to
   // the state being entered, so the line never sees a combinational path
   // from any input. par_bit is stable from cycle 1 on, so sampling it on the
   // DATA->PARITY edge gives the calculator's captured value.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r  <= ST_IDLE;
         cnt_r    <= '0;
         shift_r  <= '0;
         par_en_r <= 1'b0;
         tx_out_r <= 1'b1;
         busy_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_STOP: begin
               if (accept_s) begin
                  state_r  <= ST_START;
                  shift_r  <= P_DATA;
                  par_en_r <= PAR_EN;
                  cnt_r    <= '0;
                  tx_out_r <= 1'b0;
                  busy_r   <= 1'b1;
               end else begin
                  state_r  <= ST_IDLE;
                  tx_out_r <= 1'b1;
                  busy_r   <= 1'b0;
               end
            end
            ST_START: begin
               state_r  <= ST_DATA;
               tx_out_r <= shift_r[0];
               busy_r   <= 1'b1;
            end
            ST_DATA: begin
               busy_r <= 1'b1;
               if (cnt_r == LAST_CNT) begin
                  if (par_en_r) begin
                     state_r  <= ST_PARITY;
                     tx_out_r <= par_bit;
                  end else begin
                     state_r  <= ST_STOP;
                     tx_out_r <= 1'b1;
                  end
               end else begin
                  // Next bit on the line is the one about to reach bit 0.
                  shift_r  <= {1'b0, shift_r[DATA_WIDTH-1:1]};
                  cnt_r    <= cnt_r + CNT_ONE;
                  tx_out_r <= shift_r[1];
               end
            end
            ST_PARITY: begin
               state_r  <= ST_STOP;
               tx_out_r <= 1'b1;
               busy_r   <= 1'b1;
            end
            default: begin
               state_r  <= ST_IDLE;
               cnt_r    <= '0;
               tx_out_r <= 1'b1;
               busy_r   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Self-checking bench for uart_tx_ctrl (DATA_WIDTH = 8). A small parity
// calculator model feeds par_bit. A frame-level reference model keeps a queue
// of the line bits still to be sent: each accepted word appends
// {start, data LSB first, optional parity, stop}, and one bit is consumed per
// clock. A known-answer table plus hand-written corner sequences and random
// traffic are all checked against it.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

   localparam int W = 8;

   logic         CLK;
   logic         RST;
   logic [W-1:0] P_DATA;
   logic         DATA_VALID;
   logic         PAR_EN;
   logic         par_bit;
   logic         par_calc_en;
   logic         TX_OUT;
   logic         busy;
   logic         odd_mode;

   int           n_vec;
   int           n_err;
   int           cyc;
   logic         mq[$];
   int           pulse_cyc[$];

   typedef struct {
      logic [7:0]  data;
      logic        par_en;
      logic        odd;
      int          len;
      logic [11:0] frame;   // bit k = expected TX_OUT in cycle k+1
   } vec_t;

   vec_t tbl[7];

   uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .P_DATA      (P_DATA),
      .DATA_VALID  (DATA_VALID),
      .PAR_EN      (PAR_EN),
      .par_bit     (par_bit),
      .par_calc_en (par_calc_en),
      .TX_OUT      (TX_OUT),
      .busy        (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Parity calculator: even mode gives XOR of the data, odd mode its inverse.
   always @(posedge CLK or negedge RST) begin
      if (!RST) par_bit <= 1'b0;
      else if (par_calc_en) par_bit <= (^P_DATA) ^ odd_mode;
   end

   task automatic check(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [W-1:0] d, input logic pe, input logic odd);
      mq.push_back(1'b0);
      for (int i = 0; i < W; i++) mq.push_back(d[i]);
      if (pe) mq.push_back((^d) ^ odd);
      mq.push_back(1'b1);
   endtask

   // One clock: compare outputs against the model mid-cycle, then advance the
   // model on the rising edge. Returns 1 time unit after the edge.
   task automatic tick();
      logic acc;
      @(negedge CLK);
      check("tx_out", TX_OUT, (mq.size() == 0) ? 1'b1 : mq[0]);
      check("busy", busy, mq.size() != 0);
      check("par_calc_en", par_calc_en, DATA_VALID && (mq.size() <= 1));
      if (par_calc_en) pulse_cyc.push_back(cyc);
      @(posedge CLK);
      acc = RST && DATA_VALID && (mq.size() <= 1);
      if (!RST) mq.delete();
      else if (mq.size() != 0) void'(mq.pop_front());
      if (acc) push_frame(P_DATA, PAR_EN, odd_mode);
      cyc++;
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      cyc   = 0;
      RST        = 1'b0;
      DATA_VALID = 1'b0;
      P_DATA     = '0;
      PAR_EN     = 1'b0;
      odd_mode   = 1'b0;

      tbl[0] = '{8'hA5, 1'b0, 1'b0, 10, 12'h34A};
      tbl[1] = '{8'hA5, 1'b1, 1'b0, 11, 12'h54A};
      tbl[2] = '{8'hA5, 1'b1, 1'b1, 11, 12'h74A};
      tbl[3] = '{8'h00, 1'b0, 1'b0, 10, 12'h200};
      tbl[4] = '{8'hFF, 1'b1, 1'b0, 11, 12'h5FE};
      tbl[5] = '{8'h01, 1'b1, 1'b1, 11, 12'h402};
      tbl[6] = '{8'h80, 1'b0, 1'b0, 10, 12'h300};

      // Reset state
      #22;
      check("rst_tx_out", TX_OUT, 1'b1);
      check("rst_busy", busy, 1'b0);
      RST = 1'b1;
      #1;
      check("rst_par_calc_en", par_calc_en, 1'b0);
      tick();
      tick();

      // Known-answer frames; inputs are scrambled after accept to prove latching
      foreach (tbl[i]) begin
         tick();
         P_DATA     = tbl[i].data;
         PAR_EN     = tbl[i].par_en;
         odd_mode   = tbl[i].odd;
         DATA_VALID = 1'b1;
         #1;
         check("tbl_accept_strobe", par_calc_en, 1'b1);
         tick();
         DATA_VALID = 1'b0;
         P_DATA     = ~tbl[i].data;
         PAR_EN     = ~tbl[i].par_en;
         for (int k = 0; k < tbl[i].len; k++) begin
            check("tbl_bit", TX_OUT, tbl[i].frame[k]);
            check("tbl_busy", busy, 1'b1);
            tick();
         end
         check("tbl_end_tx", TX_OUT, 1'b1);
         check("tbl_end_busy", busy, 1'b0);
      end

      // Back-to-back 0x0F then 0xF0, second request in the STOP cycle
      tick();
      pulse_cyc.delete();
      P_DATA = 8'h0F; PAR_EN = 1'b0; DATA_VALID = 1'b1;
      tick();
      DATA_VALID = 1'b0;
      for (int k = 1; k < 10; k++) tick();
      P_DATA = 8'hF0; DATA_VALID = 1'b1;
      #1;
      check("b2b_stop_strobe", par_calc_en, 1'b1);
      tick();
      DATA_VALID = 1'b0;
      check("b2b_start_bit", TX_OUT, 1'b0);
      check("b2b_busy", busy, 1'b1);
      for (int k = 0; k < 12; k++) tick();
      check_int("b2b_pulse_count", pulse_cyc.size(), 2);
      if (pulse_cyc.size() == 2) check_int("b2b_pulse_gap", pulse_cyc[1] - pulse_cyc[0], 10);

      // DATA_VALID held with 0x33 while 0x55 is on the line
      P_DATA = 8'h55; DATA_VALID = 1'b1;
      tick();
      P_DATA = 8'h33;
      for (int k = 0; k < 10; k++) tick();
      DATA_VALID = 1'b0;
      check("hold_second_start", TX_OUT, 1'b0);
      for (int k = 0; k < 12; k++) tick();

      // Asynchronous reset in the 4th data bit of 0xFF
      P_DATA = 8'hFF; PAR_EN = 1'b1; DATA_VALID = 1'b1;
      tick();
      DATA_VALID = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check("pre_rst_busy", busy, 1'b1);
      #2;
      RST = 1'b0;
      #1;
      check("async_rst_tx_out", TX_OUT, 1'b1);
      check("async_rst_busy", busy, 1'b0);
      mq.delete();
      @(posedge CLK);
      #2;
      RST = 1'b1;
      for (int k = 0; k < 14; k++) tick();

      // PAR_EN toggled mid-frame; length follows the latched value
      for (int f = 0; f < 2; f++) begin
         P_DATA = 8'hA5; PAR_EN = (f == 1); DATA_VALID = 1'b1;
         tick();
         DATA_VALID = 1'b0;
         for (int k = 0; k < 13; k++) begin
            PAR_EN = ~PAR_EN;
            tick();
         end
      end

      // Random traffic against the model
      for (int k = 0; k < 600; k++) begin
         DATA_VALID = ($urandom_range(0, 99) < 35);
         P_DATA     = 8'($urandom);
         PAR_EN     = 1'($urandom_range(0, 1));
         odd_mode   = 1'($urandom_range(0, 1));
         tick();
      end
      DATA_VALID = 1'b0;
      for (int k = 0; k < 14; k++) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
